// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Drives SETUP/ACCESS, honours PREADY wait states and aborts hung transfers.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [2*NUM_REQ-1:0]        req_slave_id,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic                        timeout,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [3:0]                  psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [ADDR_W-1:0]           paddr,
  output logic [DATA_W-1:0]           pwdata,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic              write;
    logic [1:0]        id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_COMPLETE} state_t;

  state_t               state, nxt;
  req_t [NUM_REQ-1:0]   lane;
  req_t                 lat;
  logic [IDX_W-1:0]     win, ptr, pick;
  logic [IDX_W:0]       rr_idx;
  logic [7:0]           cnt;
  logic                 err_q, to_q, to_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = {req_write[g], req_slave_id[2*g +: 2],
                      req_addr[ADDR_W*g +: ADDR_W], req_wdata[DATA_W*g +: DATA_W]};
  end

  // Scan downwards so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    pick   = '0;
    rr_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      rr_idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (rr_idx >= (IDX_W+1)'(NUM_REQ)) rr_idx = rr_idx - (IDX_W+1)'(NUM_REQ);
      if (req[rr_idx[IDX_W-1:0]]) pick = rr_idx[IDX_W-1:0];
    end
  end

  // cnt holds ACCESS cycles already spent, so the abort fires on the TIMEOUT-th one.
  assign to_hit = (cnt == 8'(TIMEOUT-1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     if (|req) nxt = S_SETUP;
      S_SETUP:    nxt = S_ACCESS;
      S_ACCESS:   if (pready || to_hit) nxt = S_COMPLETE;
      S_COMPLETE: nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat   <= '0;
      win   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      to_q  <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          win <= pick;
          lat <= lane[pick];
        end
        S_ACCESS: begin
          cnt <= cnt + 8'd1;
          if (pready) begin
            err_q <= pslverr;
            to_q  <= 1'b0;
            if (!lat.write) rdata <= prdata;
          end else if (to_hit) begin
            err_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        S_COMPLETE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          to_q  <= 1'b0;
          ptr   <= (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus-side fields come straight from the latch so they stay stable across SETUP/ACCESS.
  assign busy    = (state != S_IDLE);
  assign psel    = (state == S_SETUP || state == S_ACCESS) ? (4'b0001 << lat.id) : 4'b0000;
  assign penable = (state == S_ACCESS);
  assign pwrite  = lat.write;
  assign paddr   = lat.addr;
  assign pwdata  = lat.wdata;
  assign done    = (state == S_COMPLETE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;
  assign err     = (state == S_COMPLETE) & err_q;
  assign timeout = (state == S_COMPLETE) & to_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed protocol cases plus randomized traffic,
// all checked every cycle against a transaction-level model.
module tb_apb_req_arbiter;
  localparam int N = 4, AW = 8, DW = 8, TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0, req_write;
  logic [2*N-1:0]  req_slave_id;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic            r_w    [N];
  logic [1:0]      r_id   [N];
  logic [AW-1:0]   r_addr [N];
  logic [DW-1:0]   r_wd   [N];
  logic [N-1:0]    done;
  logic            err, tmo, busy, penable, pwrite, pready, pslverr;
  logic [DW-1:0]   rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic [3:0]      psel;

  always_comb begin
    req_write = '0; req_slave_id = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_write[i]            = r_w[i];
      req_slave_id[2*i +: 2]  = r_id[i];
      req_addr[AW*i +: AW]    = r_addr[i];
      req_wdata[DW*i +: DW]   = r_wd[i];
    end
  end

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write),
    .req_slave_id(req_slave_id), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .timeout(tmo), .rdata(rdata), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // APB slave: directed (fixed wait count / stuck) or random ready.
  bit sl_rand = 0, sl_stuck = 0, sl_err = 0;
  int sl_waits = 0, sl_cnt = 0, sl_pq = 1;
  logic [DW-1:0] sl_rdata = '0;
  initial begin pready = 0; prdata = '0; pslverr = 0; end
  always @(posedge clk) begin
    #1;
    sl_cnt = penable ? sl_cnt + 1 : 0;
    if (sl_rand) begin
      pready  = ($urandom_range(0, sl_pq) == 0);
      prdata  = DW'($urandom);
      pslverr = ($urandom_range(0, 5) == 0);
    end else begin
      pready  = penable && !sl_stuck && (sl_cnt > sl_waits);
      prdata  = sl_rdata;
      pslverr = sl_err && pready;
    end
  end

  // Transaction model: a transfer is SETUP (m_cyc 0), ACCESS cycles, then one COMPLETE cycle at m_end.
  bit m_act, m_w, m_err, m_to;
  int m_cyc, m_end, m_win, m_ptr, m_id;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_ptr = 0; m_rdata = '0; m_err = 0; m_to = 0; m_end = -1; m_cyc = 0;
      m_win = 0; m_id = 0;
    end else if (m_act) begin
      if (m_cyc == m_end) begin
        m_act = 0;
        m_ptr = (m_win + 1) % N;
      end else begin
        if (m_cyc >= 1 && m_end < 0) begin
          if (pready) begin
            m_end = m_cyc + 1; m_err = pslverr; m_to = 0;
            if (!m_w) m_rdata = prdata;
          end else if (m_cyc == TO) begin
            m_end = m_cyc + 1; m_err = 1; m_to = 1;
          end
        end
        m_cyc++;
      end
    end else if (req != '0) begin
      for (int k = N-1; k >= 0; k--) if (req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      m_w = r_w[m_win]; m_id = int'(r_id[m_win]); m_addr = r_addr[m_win]; m_wd = r_wd[m_win];
      m_act = 1; m_cyc = 0; m_end = -1;
    end
  end

  bit e_st, e_ac, e_cp;
  always @(negedge clk) begin
    e_st = m_act && m_cyc == 0;
    e_cp = m_act && m_cyc == m_end;
    e_ac = m_act && !e_st && !e_cp;
    chk("psel",    psel,    (e_st || e_ac) ? 32'(1 << m_id) : 32'd0);
    chk("penable", penable, e_ac);
    chk("busy",    busy,    m_act);
    chk("done",    done,    e_cp ? 32'(1 << m_win) : 32'd0);
    chk("err",     err,     e_cp && m_err);
    chk("timeout", tmo,     e_cp && m_to);
    chk("rdata",   rdata,   m_rdata);
    if (e_st || e_ac) begin
      chk("pwrite", pwrite, m_w);
      chk("paddr",  paddr,  m_addr);
      chk("pwdata", pwdata, m_wd);
    end
  end

  task automatic start(input int i, input bit w, input int id, input int a, input int d);
    r_w[i] = w; r_id[i] = 2'(id); r_addr[i] = AW'(a); r_wd[i] = DW'(d); req[i] = 1'b1;
  endtask

  // Observes one transfer for requester i, from the cycle req is first seen to its done.
  int d_lat, d_ps, d_pe, d_abad;
  logic [3:0] d_sel, d_psel_c;
  logic [N-1:0] d_hit;
  logic d_err, d_to, d_pen_c;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] d_a0;
  task automatic measure(input int i);
    d_lat = 0; d_ps = 0; d_pe = 0; d_abad = 0; d_sel = '0; d_hit = '0; d_a0 = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      d_lat++;
      if (psel != 0) begin
        d_ps++; d_sel |= psel;
        if (d_ps == 1) d_a0 = paddr; else if (paddr !== d_a0) d_abad++;
      end
      if (penable) d_pe++;
      if (done != 0) begin
        d_hit = done; d_err = err; d_to = tmo; d_rdata = rdata;
        d_psel_c = psel; d_pen_c = penable;
        break;
      end
    end
    chk("done_who", d_hit, 32'(1 << i));
  endtask

  task automatic stop(input int i);
    @(posedge clk); #1 req[i] = 1'b0;
  endtask

  int rr_who [5];
  int rr_at  [5];
  int nd;
  initial begin
    for (int i = 0; i < N; i++) begin r_w[i] = 0; r_id[i] = '0; r_addr[i] = '0; r_wd[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_psel", psel, 0); chk("rst_rdata", rdata, 0);
    #2 rst_n = 1;

    // single zero-wait write
    @(posedge clk); #1 start(2, 1, 1, 'h10, 'hA5);
    measure(2);
    chk("wr_lat", d_lat, 4); chk("wr_psel_cyc", d_ps, 2); chk("wr_pen_cyc", d_pe, 1);
    chk("wr_sel", d_sel, 4'b0010); chk("wr_err", d_err, 0);
    stop(2);

    // read with three wait states
    sl_waits = 3; sl_rdata = 'h5C;
    @(posedge clk); #1 start(0, 0, 3, 'h20, 'h00);
    measure(0);
    chk("rd_pen_cyc", d_pe, 4); chk("rd_rdata", d_rdata, 'h5C); chk("rd_addr_stable", d_abad, 0);
    chk("rd_sel", d_sel, 4'b1000); chk("rd_lat", d_lat, 7);
    stop(0);

    // slave error
    sl_waits = 0; sl_err = 1;
    @(posedge clk); #1 start(1, 1, 0, 'h33, 'h44);
    measure(1);
    chk("se_err", d_err, 1); chk("se_to", d_to, 0);
    stop(1);
    sl_err = 0;

    // timeout with ready stuck low
    sl_stuck = 1; sl_rdata = 'hEE;
    @(posedge clk); #1 start(3, 0, 2, 'h40, 'h00);
    measure(3);
    chk("to_pen_cyc", d_pe, TO); chk("to_err", d_err, 1); chk("to_flag", d_to, 1);
    chk("to_psel_c", d_psel_c, 0); chk("to_pen_c", d_pen_c, 0); chk("to_rdata_kept", d_rdata, 'h5C);
    stop(3);

    // reset mid-ACCESS; pointer is 2 beforehand so a surviving pointer would pick requester 3
    sl_stuck = 0;
    @(posedge clk); #1 start(1, 1, 0, 'h01, 'h02);
    measure(1); stop(1);
    sl_stuck = 1;
    @(posedge clk); #1 start(3, 0, 1, 'h55, 'h00);
    for (int n = 0; n < 10 && !penable; n++) @(negedge clk);
    repeat (2) @(posedge clk);
    #1 start(1, 1, 2, 'h66, 'h77);
    @(negedge clk); #2 rst_n = 0;
    #1;
    chk("mr_psel", psel, 0); chk("mr_pen", penable, 0); chk("mr_busy", busy, 0); chk("mr_done", done, 0);
    @(posedge clk); @(posedge clk); @(negedge clk); #2 rst_n = 1;
    sl_stuck = 0;
    measure(1);
    chk("mr_sel", d_sel, 4'b0100);
    @(posedge clk); #1 req = '0;

    // round robin with everyone requesting after a fresh reset
    @(negedge clk); #2 rst_n = 0; @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1 for (int i = 0; i < N; i++) start(i, i[0], i, 'h80 + i, 'h90 + i);
    nd = 0;
    for (int n = 0; n < 60 && nd < 5; n++) begin
      @(negedge clk);
      if (done != 0) begin
        for (int i = 0; i < N; i++) if (done[i]) rr_who[nd] = i;
        rr_at[nd] = n; nd++;
      end
    end
    @(posedge clk); #1 req = '0;
    chk("rr_count", nd, 5);
    for (int k = 0; k < 5 && k < nd; k++) chk($sformatf("rr_order%0d", k), rr_who[k], k % N);
    for (int k = 1; k < 5 && k < nd; k++) chk($sformatf("rr_gap%0d", k), rr_at[k] - rr_at[k-1], 4);

    // randomized traffic
    sl_rand = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (c % 400 == 0) sl_pq = (sl_pq == 1) ? 15 : 1;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0)
            start(i, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
        end else if ($urandom_range(0, 40) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          r_addr[i] = AW'($urandom); r_wd[i] = DW'($urandom); r_w[i] = 1'($urandom);
        end
      end
    end
    req = '0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("end_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
